// File: rtl/pipe_pkg.sv
// Shared control-bundle layout for the pipeline stage registers.
// Stage boundaries are built from pipe_stage_reg; the skid option is PIPE_STAGE_SKID_EN.
package pipe_pkg;

   localparam int ALUOP_W    = 3;
   localparam int MEMTOREG_W = 2;
   localparam int WMASK_W    = 8;
   localparam int FUNCT3_W   = 3;

   // Fields are ordered LSB-first by the stage where they are last consumed.
   // Each later stage can therefore keep only an upper slice of the bundle.
   localparam int OFS_ALUOP    = 0;
   localparam int OFS_ALUSRC   = OFS_ALUOP + ALUOP_W;
   localparam int OFS_BRANCH   = OFS_ALUSRC + 1;
   localparam int OFS_JUMP     = OFS_BRANCH + 1;
   localparam int OFS_MEMREAD  = OFS_JUMP + 1;
   localparam int OFS_MEMWRITE = OFS_MEMREAD + 1;
   localparam int OFS_WMASK    = OFS_MEMWRITE + 1;
   localparam int OFS_FUNCT3   = OFS_WMASK + WMASK_W;
   localparam int OFS_REGWRITE = OFS_FUNCT3 + FUNCT3_W;
   localparam int OFS_MEMTOREG = OFS_REGWRITE + 1;
   localparam int OFS_ISWORD   = OFS_MEMTOREG + MEMTOREG_W;
   localparam int OFS_CSREN    = OFS_ISWORD + 1;

   localparam int CTRL_W_IDEX  = OFS_CSREN + 1;
   localparam int CTRL_W_EXMEM = CTRL_W_IDEX - OFS_MEMREAD;
   localparam int CTRL_W_MEMWB = CTRL_W_IDEX - OFS_REGWRITE;
   // IF/ID carries no control; one bit keeps the port non-degenerate.
   localparam int CTRL_W_IFID  = 1;

   localparam logic [CTRL_W_IDEX-1:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      ST_IFID  = 2'd0,
      ST_IDEX  = 2'd1,
      ST_EXMEM = 2'd2,
      ST_MEMWB = 2'd3
   } stage_e;

   typedef struct packed {
      logic                  csr_en;
      logic                  is_word;
      logic [MEMTOREG_W-1:0] memtoreg;
      logic                  reg_write;
      logic [FUNCT3_W-1:0]   funct3;
      logic [WMASK_W-1:0]    wmask;
      logic                  mem_write;
      logic                  mem_read;
      logic                  jump;
      logic                  branch;
      logic                  alu_src;
      logic [ALUOP_W-1:0]    alu_op;
   } ctrl_t;

   function automatic int ctrl_w(input stage_e st);
      case (st)
         ST_IFID:  return CTRL_W_IFID;
         ST_IDEX:  return CTRL_W_IDEX;
         ST_EXMEM: return CTRL_W_EXMEM;
         default:  return CTRL_W_MEMWB;
      endcase
   endfunction

   function automatic logic [CTRL_W_IDEX-1:0] pack_ctrl(input ctrl_t c);
      return c;
   endfunction

   // True when the bundle cannot change architectural state downstream.
   function automatic logic ctrl_is_inert(input logic [CTRL_W_IDEX-1:0] v);
      return !(v[OFS_REGWRITE] || v[OFS_MEMWRITE] || v[OFS_BRANCH] || v[OFS_JUMP]);
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with valid flag, used as the skid slot of pipe_stage_reg.
// Only instantiated when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int W = 88
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic [W-1:0] beat_i,
   output logic         valid_o,
   output logic [W-1:0] beat_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] beat_q, beat_d;

   // A load on the same edge as a drain refills the slot.
   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         beat_d  = beat_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   assign valid_o = valid_q;
   assign beat_o  = beat_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready backed by a one-entry skid slot.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 24,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CTRL_W-1:0] BUBBLE  = CTRL_W'(CTRL_BUBBLE);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, emit;

   assign accept = in_valid && in_ready;
   assign emit   = valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   localparam int BEAT_W = DATA_W + CTRL_W;

   logic              sk_valid, sk_load, sk_drain;
   logic [BEAT_W-1:0] sk_beat;

   pipe_skid_buf #(.W(BEAT_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .load_i  (sk_load),
      .drain_i (sk_drain),
      .beat_i  ({in_ctrl, in_data}),
      .valid_o (sk_valid),
      .beat_o  (sk_beat)
   );

   assign in_ready = !sk_valid;

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      sk_load  = 1'b0;
      sk_drain = 1'b0;
      if (!valid_q || emit) begin
         // Main frees up: the older skid beat takes precedence over the input.
         if (sk_valid) begin
            {ctrl_d, data_d} = sk_beat;
            valid_d          = 1'b1;
            sk_drain         = 1'b1;
            sk_load          = accept;
         end else if (accept) begin
            data_d  = in_data;
            ctrl_d  = in_ctrl;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else begin
         sk_load = accept;
      end
      if (flush) valid_d = 1'b0;
   end
`else
   assign in_ready = !valid_q || out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (accept) begin
         data_d  = in_data;
         ctrl_d  = in_ctrl;
         valid_d = 1'b1;
      end else if (emit) begin
         valid_d = 1'b0;
      end
      if (flush) valid_d = 1'b0;
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (valid_q && !out_ready && cnt_q != CNT_MAX)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ctrl  = valid_q ? ctrl_q : BUBBLE;
   assign stall_cnt = cnt_q;

endmodule
